// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared motor mode and ramp state encodings
//
// Purpose: mode codes seen by the motor driver, ramp controller state codes,
//          and the helper that folds a zero-speed target into STOP.
// Ports:   none (package).
package motor_pkg;

  localparam int SPEED_W = 10;

  typedef enum logic [1:0] {
    MODE_STOP = 2'b00,
    MODE_FWD  = 2'b01,
    MODE_BWD  = 2'b10,
    MODE_SPIN = 2'b11
  } motor_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRACK     = 3'd1,
    ST_RAMP_DOWN = 3'd2,
    ST_DEAD      = 3'd3,
    ST_ESTOP     = 3'd4
  } ramp_state_e;

  // A target asking for zero duty is the same as asking the motor to stop.
  function automatic motor_mode_e effective_mode(input motor_mode_e m,
                                                 input logic [SPEED_W-1:0] s);
    return (s == '0) ? MODE_STOP : m;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running prescaler producing a one-cycle tick
//
// Purpose: counts 0..DIV-1 and pulses tick while the count sits at DIV-1.
// Ports:   clk  - system clock
//          rst  - asynchronous active-low reset
//          tick - one-cycle pulse every DIV clocks
module tick_gen #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/motor_ramp_ctrl.sv
// rtl/motor_ramp_ctrl.sv - motor mode/speed ramp controller with dead time and e-stop
//
// Purpose: accepts mode/speed targets and drives the motor driver so that speed
//          ramps by RAMP_STEP per tick, direction changes pass through zero
//          speed and a DEAD_TICKS dead time, and estop drops the drive at once.
// Ports:   clk, rst (async active-low)
//          estop                       - level-sensitive emergency stop
//          cmd_valid/cmd_ready         - command handshake
//          cmd_mode[1:0], cmd_speed[9:0] - target mode and duty
//          mode[1:0], speed[9:0]       - registered drive to the motor driver
//          at_speed                    - drive matches the accepted target
//          state[2:0]                  - current FSM state code
module motor_ramp_ctrl
  import motor_pkg::*;
#(
  parameter int         RAMP_DIV   = 100000,
  parameter logic [9:0] RAMP_STEP  = 10'd8,
  parameter int         DEAD_TICKS = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       estop,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_mode,
  input  logic [9:0] cmd_speed,
  output logic [1:0] mode,
  output logic [9:0] speed,
  output logic       at_speed,
  output logic [2:0] state
);

  localparam int DCW = $clog2(DEAD_TICKS + 1);
  localparam logic [DCW-1:0] DEAD_LOAD = DCW'(DEAD_TICKS);

  logic tick;

  tick_gen #(.DIV(RAMP_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  ramp_state_e   state_q, state_n;
  motor_mode_e   mode_q, mode_n;
  logic [9:0]    speed_q, speed_n;
  motor_mode_e   tgt_mode_q, tgt_mode_n;
  logic [9:0]    tgt_speed_q, tgt_speed_n;
  logic [DCW-1:0] dead_q, dead_n;

  motor_mode_e eff_mode;
  logic [10:0] spd_x, tgt_x, step_x, track_spd, down_spd;

  assign eff_mode = effective_mode(tgt_mode_q, tgt_speed_q);
  assign spd_x    = {1'b0, speed_q};
  assign tgt_x    = {1'b0, tgt_speed_q};
  assign step_x   = {1'b0, RAMP_STEP};

  // One ramp step toward the target, landing exactly on it when the
  // remaining distance is no more than a step; one step toward zero.
  always_comb begin
    track_spd = spd_x;
    if (spd_x < tgt_x) begin
      track_spd = ((tgt_x - spd_x) <= step_x) ? tgt_x : (spd_x + step_x);
    end else if (spd_x > tgt_x) begin
      track_spd = ((spd_x - tgt_x) <= step_x) ? tgt_x : (spd_x - step_x);
    end
    down_spd = (spd_x > step_x) ? (spd_x - step_x) : 11'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_STOP;
      speed_q     <= '0;
      tgt_mode_q  <= MODE_STOP;
      tgt_speed_q <= '0;
      dead_q      <= '0;
    end else begin
      state_q     <= state_n;
      mode_q      <= mode_n;
      speed_q     <= speed_n;
      tgt_mode_q  <= tgt_mode_n;
      tgt_speed_q <= tgt_speed_n;
      dead_q      <= dead_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    mode_n      = mode_q;
    speed_n     = speed_q;
    tgt_mode_n  = tgt_mode_q;
    tgt_speed_n = tgt_speed_q;
    dead_n      = dead_q;

    if (cmd_valid && cmd_ready) begin
      tgt_mode_n  = motor_mode_e'(cmd_mode);
      tgt_speed_n = cmd_speed;
    end

    if (estop) begin
      // Drive is cut in the same update; a command landing on this edge is lost.
      state_n     = ST_ESTOP;
      mode_n      = MODE_STOP;
      speed_n     = '0;
      tgt_mode_n  = MODE_STOP;
      tgt_speed_n = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (eff_mode != MODE_STOP) begin
            mode_n  = tgt_mode_q;
            state_n = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (eff_mode != mode_q) begin
            state_n = ST_RAMP_DOWN;
          end else if (tick) begin
            speed_n = track_spd[9:0];
          end
        end
        ST_RAMP_DOWN: begin
          if (eff_mode == mode_q) begin
            state_n = ST_TRACK;
          end else if (speed_q == '0) begin
            mode_n  = MODE_STOP;
            dead_n  = DEAD_LOAD;
            state_n = ST_DEAD;
          end else if (tick) begin
            speed_n = down_spd[9:0];
          end
        end
        ST_DEAD: begin
          if (tick) begin
            if (dead_q <= DCW'(1)) begin
              dead_n  = '0;
              state_n = ST_IDLE;
            end else begin
              dead_n = dead_q - DCW'(1);
            end
          end
        end
        ST_ESTOP: begin
          dead_n  = DEAD_LOAD;
          state_n = ST_DEAD;
        end
        default: begin
          mode_n  = MODE_STOP;
          speed_n = '0;
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_TRACK) ||
                     (state_q == ST_RAMP_DOWN);
  assign at_speed  = ((state_q == ST_TRACK) && (mode_q == eff_mode) &&
                      (speed_q == tgt_speed_q)) ||
                     ((state_q == ST_IDLE) && (eff_mode == MODE_STOP));
  assign mode      = mode_q;
  assign speed     = speed_q;
  assign state     = state_q;

endmodule

// File: doc/motor_ramp_ctrl.md
MOTOR_RAMP_CTRL -- requirements
Module: motor_ramp_ctrl

Interface
REQ-001 Parameter RAMP_DIV, default 100000, clk cycles per ramp tick (>=2).
REQ-002 Parameter RAMP_STEP, default 10'd8, speed change per ramp tick (>=1).
REQ-003 Parameter DEAD_TICKS, default 50, ramp ticks held in STOP before any direction change (>=1).
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 estop  input  1  emergency stop, level-sensitive, active-high.
REQ-007 cmd_valid  input  1  command offered.
REQ-008 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready on a clk edge.
REQ-009 cmd_mode  input  2  target mode: 00 STOP, 01 FWD, 10 BWD, 11 SPIN.
REQ-010 cmd_speed  input  10  target duty, 0..1023.
REQ-011 mode  output  2  mode driven to the motor driver.
REQ-012 speed  output  10  duty driven to the motor driver.
REQ-013 at_speed  output  1  mode and speed equal the accepted target.
REQ-014 state  output  3  current FSM state code.

Function
REQ-015 Internal prescaler SHALL count 0..RAMP_DIV-1 free-running, producing a one-cycle tick at RAMP_DIV-1.
REQ-016 Accepted command SHALL overwrite target registers (tgt_mode, tgt_speed); the last accepted command wins, with no queue.
REQ-017 cmd_ready SHALL be 1 in IDLE, TRACK and RAMP_DOWN, and 0 in DEAD and ESTOP.
REQ-018 Target with tgt_speed==0 SHALL be treated as tgt_mode STOP.
REQ-019 States: IDLE=0, TRACK=1, RAMP_DOWN=2, DEAD=3, ESTOP=4.
REQ-020 IDLE: mode=00, speed=0; when the effective target is not STOP, next cycle mode<=tgt_mode and go to TRACK; speed stays 0 until the first tick.
REQ-021 TRACK, target mode equal to mode: on each tick speed moves toward tgt_speed by RAMP_STEP, saturating exactly at tgt_speed with no overshoot; computation is 11-bit and clamps to 0..1023.
REQ-022 TRACK, effective target mode different from mode (including STOP): go to RAMP_DOWN, holding mode.
REQ-023 RAMP_DOWN: on each tick speed decreases by RAMP_STEP, floored at 0; mode is held; when speed==0, go to DEAD with mode<=00 and the dead counter loaded.
REQ-024 RAMP_DOWN, target reverts to the current mode before speed reaches 0: return to TRACK and resume tracking from the present speed.
REQ-025 DEAD: mode=00, speed=0; after DEAD_TICKS ticks go to IDLE.
REQ-026 Any state, estop=1: go to ESTOP on the next edge with speed=0 and mode=00 in the same update, bypassing the ramp; target cleared to STOP/0.
REQ-027 ESTOP: commands are ignored; when estop=0, go to DEAD (a full dead time is applied) and then to IDLE.
REQ-028 at_speed SHALL be 1 only in TRACK with mode==tgt_mode and speed==tgt_speed, or in IDLE with the target at STOP.
REQ-029 Outputs SHALL be registered, with no combinational path from cmd_* or estop to mode or speed.
REQ-030 mode SHALL never change directly between two non-STOP codes.

Reset
REQ-031 rst=0 SHALL asynchronously force state=IDLE, mode=00, speed=0, at_speed=1, target=STOP/0, prescaler=0, dead counter=0; cmd_ready=1 after release.
REQ-032 Reset mid-ramp SHALL drop speed to 0 immediately, with no ramp-down.

Structure
REQ-033 Mode encodings (STOP/FWD/BWD/SPIN) and state codes SHALL live in a shared motor_pkg include, also used by the motor driver.
REQ-034 The prescaler SHALL be a sub-module tick_gen (params DIV; ports clk, rst, tick).
REQ-035 Outputs mode and speed SHALL connect directly to the existing motor driver's mode and speed inputs.

Verification (RAMP_DIV=4, RAMP_STEP=100, DEAD_TICKS=2)
REQ-036 Assert rst=0 mid-operation -> mode=00, speed=0, state=0 immediately; cmd_ready=1 after release.
REQ-037 From IDLE, cmd FWD/700 -> mode=01 after 1 cycle; speed 100,200,...,700 every 4 cycles; at_speed=1 after the 7th tick.
REQ-038 In TRACK FWD/700, cmd FWD/350 -> speed 600,500,400,350, then at_speed=1; mode remains 01 throughout.
REQ-039 In TRACK FWD/300, cmd BWD/300 -> speed 200,100,0 with mode 01; then mode=00 for 2 ticks with cmd_ready=0; then mode=10 and speed 100,200,300.
REQ-040 During ramp at speed 400, estop=1 -> next edge speed=0, mode=00, state=4, cmd_ready=0; estop=0 -> DEAD for 2 ticks, then IDLE.
REQ-041 In RAMP_DOWN from FWD toward BWD at speed 200, cmd FWD/500 -> returns to TRACK and ramps 300,400,500 with mode never leaving 01.
